// File: rtl/key_event_queue.sv
// Key event queue: rising-edge detects seven key lines and queues the index of
// each pressed key in a small FIFO, flagging any event that had to be thrown away.
module key_event_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [6:0]               key_in,
  input  logic                     rd,
  input  logic                     clr_drop,
  output logic [2:0]               key_code,
  output logic                     key_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [6:0]    keyPrev_q;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          dropped_q, dropped_d;
  logic [2:0]    mem_q [DEPTH];

  logic [6:0] edges;
  logic       evValid;
  logic       evMulti;
  logic [2:0] evCode;
  logic       popEn;
  logic       pushEn;
  logic       dropNow;

  // Lowest index wins when several keys go down together; the rest count as drops.
  always_comb begin
    edges   = key_in & ~keyPrev_q;
    evValid = |edges;
    evMulti = |(edges & (edges - 7'd1));
    evCode  = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (edges[i]) evCode = 3'(i);
    end
  end

  assign key_valid = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign dropped   = dropped_q;
  assign key_code  = key_valid ? mem_q[rdPtr_q] : 3'b111;

  // A full queue still accepts a new key if the consumer frees a slot on the same edge.
  always_comb begin
    popEn     = rd && key_valid;
    pushEn    = evValid && (!full || popEn);
    dropNow   = evMulti || (evValid && full && !popEn);
    rdPtr_d   = rdPtr_q + AW'(popEn);
    wrPtr_d   = wrPtr_q + AW'(pushEn);
    count_d   = count_q + CW'(pushEn) - CW'(popEn);
    dropped_d = dropped_q;
    if (dropNow) begin
      dropped_d = 1'b1;
    end else if (clr_drop) begin
      dropped_d = 1'b0;
    end
  end

  // keyPrev resets to all-ones so keys held through reset release stay silent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyPrev_q <= 7'h7F;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 3'd0;
      end
    end else begin
      keyPrev_q <= key_in;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
      if (pushEn) begin
        mem_q[wrPtr_q] <= evCode;
      end
    end
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Scenario bench for key_event_queue: a behavioural FIFO model fills a scoreboard
// of expected key codes, which are checked against the queue head before each pop.
module tb_key_event_queue;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [6:0] key_in;
  logic       rd;
  logic       clr_drop;
  logic [2:0] key_code;
  logic       key_valid;
  logic [2:0] count;
  logic       full;
  logic       dropped;

  int total = 0;
  int bad   = 0;

  logic [2:0] sbQ[$];
  logic [6:0] mPrev;
  logic       mDropped;
  logic [2:0] want;

  key_event_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .rd(rd), .clr_drop(clr_drop),
    .key_code(key_code), .key_valid(key_valid), .count(count),
    .full(full), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one clock of inputs and advances the reference queue the way the block should.
  task automatic applyStimulus(input logic [6:0] k, input logic r, input logic c);
    logic [6:0] e;
    logic       popOk;
    logic       mFull;
    logic       found;
    logic [2:0] code;
    key_in   = k;
    rd       = r;
    clr_drop = c;
    e        = k & ~mPrev;
    popOk    = r && (sbQ.size() > 0);
    mFull    = (sbQ.size() == DEPTH);
    found    = 1'b0;
    code     = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (e[i] && !found) begin
        code  = 3'(i);
        found = 1'b1;
      end
    end
    if (popOk) void'(sbQ.pop_front());
    if (found && (!mFull || popOk)) sbQ.push_back(code);
    if (($countones(e) > 1) || (found && mFull && !popOk)) mDropped = 1'b1;
    else if (c) mDropped = 1'b0;
    mPrev = k;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    sbQ.delete();
    mPrev    = 7'h7F;
    mDropped = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_in = 7'd0; rd = 1'b0; clr_drop = 1'b0;
    modelReset();
    #1;
    total++;
    if (key_valid !== 1'b0 || count !== 3'd0 || full !== 1'b0 || dropped !== 1'b0 || key_code !== 3'd7) begin
      bad++;
      $display("[TB] FAIL reset_state got v=%b c=%0d f=%b d=%b k=%0d want v=0 c=0 f=0 d=0 k=7",
               key_valid, count, full, dropped, key_code);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(7'd0, 1'b0, 1'b0);
    applyStimulus(7'd0, 1'b1, 1'b0);
    total++;
    if (count !== 3'd0 || key_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rd_on_empty got count=%0d valid=%b want count=0 valid=0", count, key_valid);
    end
  endtask

  task automatic test_single_press();
    applyStimulus(7'b0000100, 1'b0, 1'b0);
    total++;
    if (key_valid !== 1'b1 || count !== 3'd1 || key_code !== 3'd2) begin
      bad++;
      $display("[TB] FAIL single_first got v=%b c=%0d k=%0d want v=1 c=1 k=2", key_valid, count, key_code);
    end
    applyStimulus(7'b0000100, 1'b0, 1'b0);
    applyStimulus(7'b0000100, 1'b0, 1'b0);
    total++;
    if (count !== 3'(sbQ.size()) || count !== 3'd1) begin
      bad++;
      $display("[TB] FAIL single_held got count=%0d want count=1", count);
    end
    applyStimulus(7'd0, 1'b0, 1'b0);
    want = sbQ[0];
    total++;
    if (key_code !== want) begin
      bad++;
      $display("[TB] FAIL single_pop got=%0d want=%0d", key_code, want);
    end
    applyStimulus(7'd0, 1'b1, 1'b0);
    total++;
    if (count !== 3'd0 || key_code !== 3'd7) begin
      bad++;
      $display("[TB] FAIL single_empty got count=%0d code=%0d want count=0 code=7", count, key_code);
    end
  endtask

  task automatic test_overflow();
    logic [6:0] keys [5];
    keys = '{7'b0000010, 7'b0001000, 7'b0100000, 7'b1000000, 7'b0000001};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(keys[i], 1'b0, 1'b0);
      applyStimulus(7'd0, 1'b0, 1'b0);
    end
    total++;
    if (count !== 3'd4 || full !== 1'b1 || dropped !== 1'b1 || dropped !== mDropped) begin
      bad++;
      $display("[TB] FAIL overflow_state got c=%0d f=%b d=%b want c=4 f=1 d=1", count, full, dropped);
    end
    for (int i = 0; i < 4; i++) begin
      want = sbQ[0];
      total++;
      if (key_code !== want) begin
        bad++;
        $display("[TB] FAIL overflow_pop%0d got=%0d want=%0d", i, key_code, want);
      end
      applyStimulus(7'd0, 1'b1, 1'b0);
    end
    total++;
    if (key_valid !== 1'b0 || key_code !== 3'd7 || full !== 1'b0) begin
      bad++;
      $display("[TB] FAIL overflow_drained got v=%b k=%0d f=%b want v=0 k=7 f=0", key_valid, key_code, full);
    end
    applyStimulus(7'd0, 1'b0, 1'b1);
    total++;
    if (dropped !== 1'b0) begin
      bad++;
      $display("[TB] FAIL overflow_clr got=%b want=0", dropped);
    end
  endtask

  task automatic test_simultaneous();
    applyStimulus(7'd0, 1'b0, 1'b0);
    applyStimulus(7'b0101000, 1'b0, 1'b0);
    total++;
    if (count !== 3'd1 || key_code !== 3'd3 || dropped !== 1'b1) begin
      bad++;
      $display("[TB] FAIL simul_enq got c=%0d k=%0d d=%b want c=1 k=3 d=1", count, key_code, dropped);
    end
    applyStimulus(7'b0101000, 1'b0, 1'b1);
    total++;
    if (dropped !== 1'b0 || count !== 3'd1) begin
      bad++;
      $display("[TB] FAIL simul_clr got d=%b c=%0d want d=0 c=1", dropped, count);
    end
    applyStimulus(7'd0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(7'(1 << i), 1'b0, 1'b0);
      applyStimulus(7'd0, 1'b0, 1'b0);
    end
    applyStimulus(7'b1000000, 1'b1, 1'b0);
    total++;
    if (count !== 3'd4 || full !== 1'b1 || dropped !== 1'b0 || key_code !== 3'd1) begin
      bad++;
      $display("[TB] FAIL full_pushpop got c=%0d f=%b d=%b k=%0d want c=4 f=1 d=0 k=1",
               count, full, dropped, key_code);
    end
    applyStimulus(7'b0000100, 1'b0, 1'b1);
    total++;
    if (dropped !== 1'b1 || count !== 3'd4) begin
      bad++;
      $display("[TB] FAIL set_wins got d=%b c=%0d want d=1 c=4", dropped, count);
    end
    applyStimulus(7'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      want = sbQ[0];
      total++;
      if (key_code !== want) begin
        bad++;
        $display("[TB] FAIL full_drain%0d got=%0d want=%0d", i, key_code, want);
      end
      applyStimulus(7'd0, 1'b1, 1'b0);
    end
    applyStimulus(7'b0000010, 1'b1, 1'b0);
    total++;
    if (count !== 3'd1 || key_code !== 3'd1) begin
      bad++;
      $display("[TB] FAIL empty_pushpop got c=%0d k=%0d want c=1 k=1", count, key_code);
    end
    applyStimulus(7'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    applyStimulus(7'b0000100, 1'b0, 1'b0);
    applyStimulus(7'd0, 1'b0, 1'b0);
    applyStimulus(7'b0010000, 1'b0, 1'b0);
    applyStimulus(7'd0, 1'b0, 1'b0);
    applyStimulus(7'b0100000, 1'b0, 1'b0);
    applyStimulus(7'd0, 1'b0, 1'b0);
    total++;
    if (count !== 3'd3) begin
      bad++;
      $display("[TB] FAIL mid_prefill got=%0d want=3", count);
    end
    #2;
    key_in = 7'b0000001;
    rst    = 1'b1;
    #1;
    total++;
    if (count !== 3'd0 || key_valid !== 1'b0 || full !== 1'b0 || dropped !== 1'b0 || key_code !== 3'd7) begin
      bad++;
      $display("[TB] FAIL mid_reset got c=%0d v=%b f=%b d=%b k=%0d want 0/0/0/0/7",
               count, key_valid, full, dropped, key_code);
    end
    modelReset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(7'b0000001, 1'b0, 1'b0);
    applyStimulus(7'b0000001, 1'b0, 1'b0);
    total++;
    if (count !== 3'd0 || key_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL held_through_reset got c=%0d v=%b want c=0 v=0", count, key_valid);
    end
    applyStimulus(7'd0, 1'b0, 1'b0);
    applyStimulus(7'b0000001, 1'b0, 1'b0);
    total++;
    if (count !== 3'd1 || key_code !== 3'd0) begin
      bad++;
      $display("[TB] FAIL repress got c=%0d k=%0d want c=1 k=0", count, key_code);
    end
    applyStimulus(7'd0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(7'b0010000, 1'b0, 1'b0);
      want = sbQ[0];
      total++;
      if (count !== 3'd1 || key_code !== want || want !== 3'd4) begin
        bad++;
        $display("[TB] FAIL wrap%0d got c=%0d k=%0d want c=1 k=%0d", i, count, key_code, want);
      end
      applyStimulus(7'd0, 1'b1, 1'b0);
    end
    total++;
    if (dropped !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("[TB] FAIL wrap_end got d=%b c=%0d want d=0 c=0", dropped, count);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_overflow();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
